// File: rtl/result_check_pkg.sv
// Shared types and defaults for the golden-vs-netlist result checker.
package result_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } chk_state_e;

    localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;

    always_comb begin
        q_d = q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q_d = q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/result_compare_checker.sv
// Compares golden and post-route output streams per valid sample, counts mismatches,
// records the first failing index and reports pass/fail after NUM_SAMPLES samples.
module result_compare_checker
    import result_check_pkg::*;
#(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned NUM_SAMPLES = 504,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] netlist,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_fail_vld,
    output logic [CNT_W-1:0] first_fail_idx
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    chk_state_e       state_q, state_d;
    logic             busy_d, done_d, pass_d;
    logic [CNT_W-1:0] sample_cnt_d;
    logic             first_fail_vld_d;
    logic [CNT_W-1:0] first_fail_idx_d;

    logic accept;
    logic mismatch;
    logic last_sample;

    // A start cycle never accepts its own sample, whatever the state.
    assign accept      = (state_q == ST_RUN) && in_valid && !start;
    assign mismatch    = accept && (golden != netlist);
    assign last_sample = accept && (sample_cnt == LAST_IDX);

    always_comb begin
        state_d          = state_q;
        busy_d           = busy;
        done_d           = done;
        pass_d           = pass;
        sample_cnt_d     = sample_cnt;
        first_fail_vld_d = first_fail_vld;
        first_fail_idx_d = first_fail_idx;

        if (start) begin
            state_d          = ST_RUN;
            busy_d           = 1'b1;
            done_d           = 1'b0;
            pass_d           = 1'b0;
            sample_cnt_d     = '0;
            first_fail_vld_d = 1'b0;
            first_fail_idx_d = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        sample_cnt_d = sample_cnt + CNT_W'(1);
                        if (mismatch && !first_fail_vld) begin
                            first_fail_vld_d = 1'b1;
                            first_fail_idx_d = sample_cnt;
                        end
                        if (last_sample) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            // Final sample's mismatch is not yet in mismatch_cnt.
                            pass_d  = (mismatch_cnt == '0) && !mismatch;
                        end
                    end
                end
                ST_IDLE, ST_DONE: ;
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            sample_cnt     <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            state_q        <= state_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            sample_cnt     <= sample_cnt_d;
            first_fail_vld <= first_fail_vld_d;
            first_fail_idx <= first_fail_idx_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_mismatch_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start),
        .inc  (mismatch),
        .q    (mismatch_cnt)
    );

endmodule
